// File: rtl/bp_stall_hist_pkg.sv
// Shared types and constants for the stall-reason histogram.
// Bin numbering: stall reasons occupy 0..num_reasons-1, the retiring-cycle bin follows.
package bp_stall_hist_pkg;

    localparam int num_reasons_gp = 33;
    localparam int e_bin_instret  = num_reasons_gp;

    typedef enum logic [5:0] {
        e_unknown         = 6'd0,
        e_icache_rollback = 6'd1,
        e_icache_fence    = 6'd2,
        e_icache_miss     = 6'd3,
        e_itlb_miss       = 6'd4,
        e_itlb_fill       = 6'd5,
        e_branch_override = 6'd6,
        e_ret_override    = 6'd7,
        e_fe_cmd          = 6'd8,
        e_fe_cmd_fence    = 6'd9,
        e_mispredict      = 6'd10,
        e_control_haz     = 6'd11,
        e_long_haz        = 6'd12,
        e_data_haz        = 6'd13,
        e_aux_haz         = 6'd14,
        e_struct_haz      = 6'd15,
        e_dcache_rollback = 6'd16,
        e_dcache_miss     = 6'd17,
        e_dtlb_miss       = 6'd18,
        e_dtlb_fill       = 6'd19,
        e_eret            = 6'd20,
        e_exception       = 6'd21,
        e_interrupt       = 6'd22,
        e_fence           = 6'd23,
        e_sfence          = 6'd24,
        e_cmd_fence       = 6'd25,
        e_mul_haz         = 6'd26,
        e_div_haz         = 6'd27,
        e_fpu_haz         = 6'd28,
        e_load_dep        = 6'd29,
        e_store_buf_full  = 6'd30,
        e_resume          = 6'd31,
        e_fe_queue_full   = 6'd32
    } stall_reason_e;

    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bp_stall_hist_channel.sv
// One hart's classifier, S1 register, saturating counter bank and sticky overflow bit.
// An event sampled at edge t lands in S1 at t and in its counter at t+1; clear beats increment.
module bp_stall_hist_channel
    import bp_stall_hist_pkg::*;
#(
    parameter int num_reasons_p = num_reasons_gp,
    parameter int ctr_width_p   = 32,
    localparam int num_bins_lp  = num_reasons_p + 1,
    localparam int bin_width_lp = safe_clog2(num_reasons_p + 1),
    localparam int enc_width_lp = safe_clog2(num_reasons_p)
) (
    input  logic                               clk_i,
    input  logic                               reset_li,
    input  logic                               en,
    input  logic                               instret,
    input  logic [num_reasons_p-1:0]           reason,
    input  logic                               clear,
    output logic [num_bins_lp*ctr_width_p-1:0] ctrs,
    output logic                               ovf
);

    localparam logic [ctr_width_p-1:0] ctr_max = '1;

    logic [enc_width_lp-1:0] enc_addr;
    logic                    enc_v;
    logic [bin_width_lp-1:0] bin_sel;
    logic [bin_width_lp-1:0] s1_bin;
    logic                    s1_vld;
    logic [ctr_width_p-1:0]  ctr_r [num_bins_lp];
    logic                    sat_hit;

    bsg_priority_encode #(
        .width_p    (num_reasons_p),
        .lo_to_hi_p (1'b0)
    ) u_enc (
        .i      (reason),
        .addr_o (enc_addr),
        .v_o    (enc_v)
    );

    always_comb begin
        bin_sel = bin_width_lp'(e_unknown);
        if (instret)
            bin_sel = bin_width_lp'(num_reasons_p);
        else if (enc_v)
            bin_sel = bin_width_lp'(enc_addr);
    end

    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            s1_vld <= 1'b0;
            s1_bin <= '0;
        end else begin
            s1_vld <= en & ~clear;
            s1_bin <= bin_sel;
        end
    end

    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            for (int b = 0; b < num_bins_lp; b++) ctr_r[b] <= '0;
        end else if (clear) begin
            for (int b = 0; b < num_bins_lp; b++) ctr_r[b] <= '0;
        end else begin
            for (int b = 0; b < num_bins_lp; b++)
                if (s1_vld && s1_bin == bin_width_lp'(b) && ctr_r[b] != ctr_max)
                    ctr_r[b] <= ctr_r[b] + ctr_width_p'(1);
        end
    end

    // Flag the increment that lands a counter on all-ones.
    always_comb begin
        sat_hit = 1'b0;
        for (int b = 0; b < num_bins_lp; b++)
            if (s1_vld && s1_bin == bin_width_lp'(b) && ctr_r[b] == ctr_max - ctr_width_p'(1))
                sat_hit = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li)
            ovf <= 1'b0;
        else if (clear)
            ovf <= 1'b0;
        else
            ovf <= ovf | sat_hit;
    end

    for (genvar b = 0; b < num_bins_lp; b++) begin : g_flat
        assign ctrs[b*ctr_width_p +: ctr_width_p] = ctr_r[b];
    end

endmodule

// File: rtl/bsg_priority_encode.sv
// Priority encoder: index of the first set bit, scanning from the low or high end.
// Purely combinational; v_o flags that any input bit is set.
module bsg_priority_encode #(
    parameter int width_p    = 1,
    parameter bit lo_to_hi_p = 1'b0,
    localparam int addr_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
    input  logic [width_p-1:0]       i,
    output logic [addr_width_lp-1:0] addr_o,
    output logic                     v_o
);

    always_comb begin
        addr_o = '0;
        v_o    = |i;
        if (lo_to_hi_p) begin
            for (int idx = width_p - 1; idx >= 0; idx--)
                if (i[idx]) addr_o = addr_width_lp'(idx);
        end else begin
            for (int idx = 0; idx < width_p; idx++)
                if (i[idx]) addr_o = addr_width_lp'(idx);
        end
    end

endmodule

// File: rtl/bp_stall_histogram.sv
// Multi-hart stall-reason histogram with clear decode and a one-entry read response buffer.
// Read response valid one cycle after acceptance; rd_ready_o = ~rd_v_o | rd_yumi_i.
module bp_stall_histogram
    import bp_stall_hist_pkg::*;
#(
    parameter int num_channels_p = 1,
    parameter int num_reasons_p  = num_reasons_gp,
    parameter int ctr_width_p    = 32,
    localparam int chan_width_lp = safe_clog2(num_channels_p),
    localparam int bin_width_lp  = safe_clog2(num_reasons_p + 1)
) (
    input  logic                                    clk_i,
    input  logic                                    reset_li,
    input  logic [num_channels_p-1:0]               en_i,
    input  logic [num_channels_p-1:0]               instret_i,
    input  logic [num_channels_p*num_reasons_p-1:0] reason_i,
    input  logic                                    clear_v_i,
    input  logic [chan_width_lp-1:0]                clear_chan_i,
    input  logic                                    rd_v_i,
    output logic                                    rd_ready_o,
    input  logic [chan_width_lp-1:0]                rd_chan_i,
    input  logic [bin_width_lp-1:0]                 rd_bin_i,
    output logic                                    rd_v_o,
    input  logic                                    rd_yumi_i,
    output logic [ctr_width_p-1:0]                  rd_data_o,
    output logic                                    rd_ovf_o,
    output logic [num_channels_p-1:0]               ovf_o
);

    localparam int num_bins_lp = num_reasons_p + 1;

    logic [num_bins_lp*ctr_width_p-1:0] chan_ctrs [num_channels_p];
    logic [num_channels_p-1:0]          clear_hit;
    logic [ctr_width_p-1:0]             rd_val;
    logic                               rd_accept;

    for (genvar c = 0; c < num_channels_p; c++) begin : g_chan
        // Out-of-range clear channels match nothing, so the clear is dropped.
        assign clear_hit[c] = clear_v_i && (clear_chan_i == chan_width_lp'(c));

        bp_stall_hist_channel #(
            .num_reasons_p (num_reasons_p),
            .ctr_width_p   (ctr_width_p)
        ) u_chan (
            .clk_i    (clk_i),
            .reset_li (reset_li),
            .en       (en_i[c]),
            .instret  (instret_i[c]),
            .reason   (reason_i[c*num_reasons_p +: num_reasons_p]),
            .clear    (clear_hit[c]),
            .ctrs     (chan_ctrs[c]),
            .ovf      (ovf_o[c])
        );
    end

    // Any channel/bin outside the populated range leaves rd_val at zero.
    always_comb begin
        rd_val = '0;
        for (int c = 0; c < num_channels_p; c++)
            for (int b = 0; b < num_bins_lp; b++)
                if (rd_chan_i == chan_width_lp'(c) && rd_bin_i == bin_width_lp'(b))
                    rd_val = chan_ctrs[c][b*ctr_width_p +: ctr_width_p];
    end

    assign rd_ready_o = ~rd_v_o | rd_yumi_i;
    assign rd_accept  = rd_v_i & rd_ready_o;

    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            rd_v_o    <= 1'b0;
            rd_data_o <= '0;
            rd_ovf_o  <= 1'b0;
        end else if (rd_accept) begin
            rd_v_o    <= 1'b1;
            rd_data_o <= rd_val;
            rd_ovf_o  <= &rd_val;
        end else if (rd_yumi_i) begin
            rd_v_o    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bp_stall_histogram.sv
// Randomized and directed bench for bp_stall_histogram against an event-history reference model.
module tb_bp_stall_histogram;

    localparam int NCH  = 3;
    localparam int NR   = 33;
    localparam int CW   = 4;
    localparam int NB   = NR + 1;
    localparam int MAXV = (1 << CW) - 1;
    localparam int MAXE = 8192;

    logic              clk_i = 1'b0;
    logic              reset_li;
    logic [NCH-1:0]    en_i;
    logic [NCH-1:0]    instret_i;
    logic [NCH*NR-1:0] reason_i;
    logic              clear_v_i;
    logic [1:0]        clear_chan_i;
    logic              rd_v_i;
    logic              rd_ready_o;
    logic [1:0]        rd_chan_i;
    logic [5:0]        rd_bin_i;
    logic              rd_v_o;
    logic              rd_yumi_i;
    logic [CW-1:0]     rd_data_o;
    logic              rd_ovf_o;
    logic [NCH-1:0]    ovf_o;

    bp_stall_histogram #(
        .num_channels_p (NCH),
        .num_reasons_p  (NR),
        .ctr_width_p    (CW)
    ) dut (
        .clk_i        (clk_i),
        .reset_li     (reset_li),
        .en_i         (en_i),
        .instret_i    (instret_i),
        .reason_i     (reason_i),
        .clear_v_i    (clear_v_i),
        .clear_chan_i (clear_chan_i),
        .rd_v_i       (rd_v_i),
        .rd_ready_o   (rd_ready_o),
        .rd_chan_i    (rd_chan_i),
        .rd_bin_i     (rd_bin_i),
        .rd_v_o       (rd_v_o),
        .rd_yumi_i    (rd_yumi_i),
        .rd_data_o    (rd_data_o),
        .rd_ovf_o     (rd_ovf_o),
        .ovf_o        (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: per-edge history of classified bins (-1 = no event) and the
    // edge of each channel's latest clear. A read at edge k sees events sampled in
    // (last clear, k-2]; the counter state after edge k holds events in (last clear, k-1].
    int       k = 0;
    int       hist [MAXE][NCH];
    int       clr [NCH];
    bit       exp_v = 1'b0;
    logic [CW-1:0] exp_data = '0;
    logic     exp_ovf = 1'b0;
    int       n_checks = 0;
    int       n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int classify(input bit inst, input logic [NR-1:0] r);
        if (inst) return NR;
        for (int i = NR - 1; i >= 0; i--)
            if (r[i]) return i;
        return 0;
    endfunction

    function automatic int count_ev(input int ch, input int b, input int lo, input int hi);
        int n = 0;
        for (int s = lo + 1; s <= hi; s++)
            if (s >= 0 && hist[s][ch] == b) n++;
        return (n > MAXV) ? MAXV : n;
    endfunction

    always @(negedge reset_li) begin
        for (int ch = 0; ch < NCH; ch++) clr[ch] = k;
        exp_v = 1'b0;
        exp_data = '0;
        exp_ovf = 1'b0;
    end

    always @(posedge clk_i) begin : mon
        int v;
        k++;
        if (k >= MAXE) begin
            $display("FAIL history_depth: actual=%0d required=<%0d", k, MAXE);
            $fatal(1);
        end
        if (!reset_li) begin
            for (int ch = 0; ch < NCH; ch++) begin
                clr[ch] = k;
                hist[k][ch] = -1;
            end
            exp_v = 1'b0;
            exp_data = '0;
            exp_ovf = 1'b0;
        end else begin
            if (rd_v_i && (!exp_v || rd_yumi_i)) begin
                v = 0;
                if (int'(rd_chan_i) < NCH && int'(rd_bin_i) <= NR)
                    v = count_ev(int'(rd_chan_i), int'(rd_bin_i), clr[int'(rd_chan_i)], k - 2);
                exp_v = 1'b1;
                exp_data = CW'(v);
                exp_ovf = (v == MAXV);
            end else if (rd_yumi_i) begin
                exp_v = 1'b0;
            end
            if (clear_v_i && int'(clear_chan_i) < NCH) clr[int'(clear_chan_i)] = k;
            for (int ch = 0; ch < NCH; ch++)
                hist[k][ch] = en_i[ch] ? classify(instret_i[ch], reason_i[ch*NR +: NR]) : -1;
        end
    end

    always @(negedge clk_i) begin : cmp
        logic [NCH-1:0] eo;
        int cnt [NB];
        if (k > 0) begin
            for (int ch = 0; ch < NCH; ch++) begin
                for (int b = 0; b < NB; b++) cnt[b] = 0;
                for (int s = clr[ch] + 1; s <= k - 1; s++)
                    if (hist[s][ch] >= 0) cnt[hist[s][ch]]++;
                eo[ch] = 1'b0;
                for (int b = 0; b < NB; b++)
                    if (cnt[b] >= MAXV) eo[ch] = 1'b1;
            end
            check("ovf_o", 64'(ovf_o), 64'(eo));
            check("rd_v_o", 64'(rd_v_o), 64'(exp_v));
            check("rd_ready_o", 64'(rd_ready_o), 64'(!exp_v || rd_yumi_i));
            check("rd_data_o", 64'(rd_data_o), 64'(exp_data));
            check("rd_ovf_o", 64'(rd_ovf_o), 64'(exp_ovf));
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input int ch, input bit inst, input logic [NR-1:0] r, input int n);
        en_i[ch] = 1'b1;
        instret_i[ch] = inst;
        reason_i[ch*NR +: NR] = r;
        repeat (n) step();
        en_i[ch] = 1'b0;
        instret_i[ch] = 1'b0;
        reason_i[ch*NR +: NR] = '0;
    endtask

    task automatic clear_chan(input int ch);
        clear_v_i = 1'b1;
        clear_chan_i = 2'(ch);
        step();
        clear_v_i = 1'b0;
    endtask

    task automatic rd_lit(input string name, input int ch, input int b, input int val, input int ovf);
        rd_v_i = 1'b1;
        rd_chan_i = 2'(ch);
        rd_bin_i = 6'(b);
        rd_yumi_i = 1'b1;
        step();
        rd_v_i = 1'b0;
        @(negedge clk_i);
        check(name, 64'(rd_data_o), 64'(val));
        if (ovf >= 0) check({name, "_ovf"}, 64'(rd_ovf_o), 64'(ovf));
        step();
    endtask

    function automatic logic [NR-1:0] onehot(input int a, input int b);
        logic [NR-1:0] r;
        r = '0;
        if (a >= 0) r[a] = 1'b1;
        if (b >= 0) r[b] = 1'b1;
        return r;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_li = 1'b0;
        en_i = '0; instret_i = '0; reason_i = '0;
        clear_v_i = 1'b0; clear_chan_i = '0;
        rd_v_i = 1'b0; rd_chan_i = '0; rd_bin_i = '0; rd_yumi_i = 1'b0;
        repeat (3) step();
        check("reset_ovf_o", 64'(ovf_o), 64'(0));
        check("reset_rd_v_o", 64'(rd_v_o), 64'(0));
        check("reset_rd_ready_o", 64'(rd_ready_o), 64'(1));
        check("reset_rd_data_o", 64'(rd_data_o), 64'(0));
        reset_li = 1'b1;
        step();

        // Highest reason wins.
        drive(0, 1'b0, onehot(5, 7), 10);
        repeat (2) step();
        rd_lit("bin7_count", 0, 7, 10, 0);
        rd_lit("bin5_count", 0, 5, 0, 0);

        // Instret bin, unknown bin, and the two-edge visibility window.
        clear_chan(0);
        drive(0, 1'b1, onehot(3, 9), 4);
        drive(0, 1'b0, '0, 3);
        rd_lit("bin0_early_read", 0, 0, 2, 0);
        rd_lit("bin0_count", 0, 0, 3, 0);
        rd_lit("instret_count", 0, NR, 4, 0);

        // Saturation and clear.
        clear_chan(0);
        drive(0, 1'b0, onehot(3, -1), 20);
        repeat (2) step();
        rd_lit("sat_bin3", 0, 3, 15, 1);
        check("sat_ovf_o0", 64'(ovf_o[0]), 64'(1));
        clear_chan(0);
        step();
        rd_lit("cleared_bin3", 0, 3, 0, 0);
        check("cleared_ovf_o0", 64'(ovf_o[0]), 64'(0));

        // Out-of-range read bin / channel and out-of-range clear.
        drive(0, 1'b0, onehot(3, -1), 2);
        repeat (2) step();
        rd_lit("oor_bin", 0, 40, 0, 0);
        rd_lit("oor_chan", 3, 3, 0, 0);
        clear_chan(3);
        step();
        rd_lit("oor_clear_noop", 0, 3, 2, 0);

        // Clear of channel 1 on its increment edge while channel 0 keeps counting.
        clear_chan(0);
        clear_chan(1);
        en_i[0] = 1'b1; reason_i[0*NR +: NR] = onehot(2, -1);
        en_i[1] = 1'b1; reason_i[1*NR +: NR] = onehot(4, -1);
        step();
        en_i[1] = 1'b0; reason_i[1*NR +: NR] = '0;
        clear_v_i = 1'b1; clear_chan_i = 2'd1;
        step();
        clear_v_i = 1'b0;
        repeat (4) step();
        en_i[0] = 1'b0; reason_i[0*NR +: NR] = '0;
        repeat (2) step();
        for (int b = 0; b < NB; b++) rd_lit("ch1_zero", 1, b, 0, -1);
        rd_lit("ch0_unaffected", 0, 2, 6, 0);

        // Response held without yumi, then replaced on a yumi+read edge.
        clear_chan(2);
        drive(2, 1'b0, onehot(1, -1), 5);
        drive(2, 1'b0, onehot(9, 0), 3);
        repeat (2) step();
        rd_yumi_i = 1'b0;
        rd_v_i = 1'b1; rd_chan_i = 2'd2; rd_bin_i = 6'd1;
        step();
        rd_bin_i = 6'd9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("hold_ready", 64'(rd_ready_o), 64'(0));
            check("hold_data", 64'(rd_data_o), 64'(5));
            check("hold_valid", 64'(rd_v_o), 64'(1));
            step();
        end
        rd_yumi_i = 1'b1;
        @(negedge clk_i);
        check("swap_ready", 64'(rd_ready_o), 64'(1));
        step();
        rd_v_i = 1'b0;
        @(negedge clk_i);
        check("swap_valid", 64'(rd_v_o), 64'(1));
        check("swap_data", 64'(rd_data_o), 64'(3));
        step();

        // Reset mid-count; counting resumes from zero after release.
        rd_lit("pre_reset_read", 2, 1, 5, 0);
        clear_chan(0);
        en_i[0] = 1'b1; reason_i[0*NR +: NR] = onehot(6, 1);
        repeat (5) step();
        reset_li = 1'b0;
        @(negedge clk_i);
        check("midrst_ovf_o", 64'(ovf_o), 64'(0));
        check("midrst_rd_v_o", 64'(rd_v_o), 64'(0));
        check("midrst_rd_ready_o", 64'(rd_ready_o), 64'(1));
        check("midrst_rd_data_o", 64'(rd_data_o), 64'(0));
        check("midrst_rd_ovf_o", 64'(rd_ovf_o), 64'(0));
        repeat (3) step();
        reset_li = 1'b1;
        repeat (4) step();
        en_i[0] = 1'b0; reason_i[0*NR +: NR] = '0;
        repeat (2) step();
        rd_lit("post_reset_count", 0, 6, 4, 0);

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                logic [NR-1:0] r;
                r = '0;
                for (int j = $urandom_range(0, 2); j > 0; j--) r[$urandom_range(0, NR - 1)] = 1'b1;
                en_i[ch] = ($urandom_range(0, 3) != 0);
                instret_i[ch] = ($urandom_range(0, 3) == 0);
                reason_i[ch*NR +: NR] = r;
            end
            clear_v_i = ($urandom_range(0, 39) == 0);
            clear_chan_i = 2'($urandom_range(0, 3));
            rd_v_i = $urandom_range(0, 1) != 0;
            rd_chan_i = 2'($urandom_range(0, 3));
            rd_bin_i = 6'($urandom_range(0, 40));
            rd_yumi_i = ($urandom_range(0, 3) != 0);
            if (cyc == 700) reset_li = 1'b0;
            if (cyc == 703) reset_li = 1'b1;
            step();
        end
        en_i = '0; instret_i = '0; reason_i = '0;
        clear_v_i = 1'b0; rd_v_i = 1'b0; rd_yumi_i = 1'b1;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_stall_histogram.md
# bp_stall_histogram

Synthesizable, multi-hart stall-reason histogram for BlackParrot cores. It sits beside the core (one channel per hart) and classifies every enabled cycle as either a retiring cycle or a single prioritised stall reason. It accumulates saturating per-reason counters. Software and the cosim host read and clear the counters through a valid/ready port, with no simulation-only file I/O.

## Interface
- num_channels_p, 1: number of harts monitored.
- num_reasons_p, 33: stall-reason bits per channel; bit 0 is "unknown".
- ctr_width_p, 32: counter width.
- chan_width_lp (local): `BSG_SAFE_CLOG2(num_channels_p)`.
- bin_width_lp (local): `BSG_SAFE_CLOG2(num_reasons_p+1)`.

- clk_i  in  1  clock.
- reset_li  in  1  reset, asynchronous, active-low.
- en_i  in  num_channels_p  per-channel count enable (low while frozen).
- instret_i  in  num_channels_p  channel retired an instruction this cycle.
- reason_i  in  num_channels_p*num_reasons_p  per-channel stall-reason vector; multiple bits may be set.
- clear_v_i  in  1  clear request.
- clear_chan_i  in  chan_width_lp  channel to clear.
- rd_v_i  in  1  read request.
- rd_ready_o  out  1  read request accepted when rd_v_i & rd_ready_o.
- rd_chan_i  in  chan_width_lp  read channel.
- rd_bin_i  in  bin_width_lp  read bin; num_reasons_p selects the instret bin.
- rd_v_o  out  1  response valid.
- rd_yumi_i  in  1  response consumed.
- rd_data_o  out  ctr_width_p  counter value.
- rd_ovf_o  out  1  the read counter is saturated.
- ovf_o  out  num_channels_p  sticky: some counter of the channel saturated.

## Operation
- Classification, per channel per cycle, applies only when en_i=1:
  - instret_i=1 → bin num_reasons_p; reason_i is ignored.
  - Otherwise → the highest set index of reason_i.
  - No reason bit set → bin 0.
- Stage S1 registers, per channel: valid = en_i, and the selected bin.
- Stage S2 increments counter[chan][bin] by 1 when the S1 valid bit is set.
- Counters saturate at 2^ctr_width_p-1 and never wrap. Reaching all-ones sets ovf_o[chan], which is sticky.
- Clear, on the clear_v_i edge:
  - Zeroes all num_reasons_p+1 counters of clear_chan_i and drops that channel's ovf_o bit.
  - Invalidates that channel's S1 entry.
  - Clear wins over a same-edge increment: the counter reads 0 after the edge.
- Read:
  - Accepted on an edge with rd_v_i & rd_ready_o. The counter value present before that edge's update is captured into the response register.
  - rd_ovf_o = captured value is all-ones.
  - rd_bin_i > num_reasons_p returns 0 with rd_ovf_o=0.
- Response buffer holds one entry:
  - rd_ready_o = ~rd_v_o | rd_yumi_i.
  - rd_data_o and rd_ovf_o stay stable while rd_v_o & ~rd_yumi_i.
  - Read accepted and yumi on the same edge → the new response replaces the old one; rd_v_o stays 1.
- Out-of-range rd_chan_i or clear_chan_i (≥ num_channels_p): a read returns 0; a clear is a no-op.

## Timing
- Reset (reset_li=0, async): all counters 0, S1 valid 0, ovf_o 0, rd_v_o 0, rd_data_o 0, rd_ovf_o 0, rd_ready_o 1.
- Event in cycle t becomes visible to a read accepted at edge t+2. A read at edge t+1 does not see it.
- Read latency: rd_v_o rises the cycle after acceptance. Back-to-back reads sustain 1 per cycle when rd_yumi_i is held high.
- en_i low → no S1 entry, and counters hold.
- Reset released mid-operation → counting resumes from zero on the first edge with reset_li=1.

## Structure
- bp_stall_hist_pkg holds:
  - the stall_reason_e enum (33 values, unknown=0 … fe_queue_full=32);
  - a bin constant e_bin_instret = num_reasons_p;
  - the default num_reasons_p.
- Sub-module bp_stall_hist_channel, instantiated num_channels_p times, holds one channel's encoder, S1 register, counter bank, saturation logic and ovf bit.
- The top level holds the clear decode, the read mux and the response register.
- Use bsg_priority_encode (hi_to_lo) for the encoder.

## Test plan
- Single channel, 10 cycles with reason_i bits 5 and 7 both set, en_i=1 → read bin 7 = 10, bin 5 = 0.
- 4 instret cycles, then 3 cycles with reason_i=0 → instret bin = 4, bin 0 = 3; a read issued on the edge after the last event excludes that event.
- ctr_width_p=4, 20 events to bin 3 → bin 3 reads 15 with rd_ovf_o=1 and ovf_o[0]=1; clear → bin 3 reads 0 and ovf_o[0]=0.
- 2 channels: clear channel 1 on the same edge as its S2 increment, while channel 0 keeps counting → channel 1 all bins 0, channel 0 unaffected.
- Reads held with rd_yumi_i=0 for 3 cycles → rd_ready_o=0 and rd_data_o stable; then yumi with a new read on the same edge → the next response arrives with rd_v_o continuous.
- Assert reset_li low mid-count → all outputs at reset values; after release, counts start from 0.
